dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 172 +++++++++++++++++
 tb/tb_dmem_resp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory response unit: fixed-latency word RAM behind a stall handshake for the M stage.
// Optional DMEM_MMIO_EN adds an LED register at 0xFFFF_FFF0 and a cycle counter at 0xFFFF_FFF4.
module dmem_resp #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_mem_rd,
   input  logic        i_mem_wr,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_stall,
   output logic        o_misaligned,
   output logic        o_err,
   output logic [7:0]  o_led
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {SRC_RAM, SRC_ZERO, SRC_LED, SRC_CYC} src_t;

   logic [31:0]   ram [DEPTH];

   state_t        state_reg, state_next;
   logic [2:0]    cnt_reg, cnt_next;
   logic [AW-1:0] idx_reg, idx_next;
   src_t          src_reg, src_next;
   logic [31:0]   rdata_reg;

   logic          load_en;
   logic [AW-1:0] load_idx;
   src_t          load_src;
   logic [31:0]   load_data;
   logic          stall;

   logic          aligned, rd_req, idle_wr, ram_we, led_hit, cyc_hit;
   src_t          req_src;
   logic [AW-1:0] req_idx;
   logic [7:0]    led_val;
   logic [31:0]   cyc_val;
   logic          unused_addr;

   assign aligned      = (i_addr[1:0] == 2'b00);
   assign rd_req       = i_mem_rd & ~i_mem_wr;
   assign req_idx      = i_addr[AW+1:2];
   assign o_misaligned = (i_mem_rd | i_mem_wr) & ~aligned;
   assign o_err        = i_mem_rd & i_mem_wr;
   assign unused_addr  = ^i_addr[31:AW+2];

`ifdef DMEM_MMIO_EN
   logic [7:0]  led_reg;
   logic [31:0] cycle_reg;

   assign led_hit = (i_addr == 32'hFFFF_FFF0);
   assign cyc_hit = (i_addr == 32'hFFFF_FFF4);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_reg   <= '0;
         cycle_reg <= '0;
      end else begin
         cycle_reg <= cycle_reg + 32'd1;
         if (idle_wr && led_hit)
            led_reg <= i_wdata[7:0];
      end
   end

   assign led_val = led_reg;
   assign cyc_val = cycle_reg;
`else
   assign led_hit = 1'b0;
   assign cyc_hit = 1'b0;
   assign led_val = 8'h00;
   assign cyc_val = 32'h0;
`endif

   assign idle_wr = (state_reg == IDLE) & i_mem_wr & aligned;
   // MMIO addresses never reach the RAM; rst gating keeps stores out while held in reset.
   assign ram_we  = idle_wr & ~led_hit & ~cyc_hit & rst;

   always_comb begin
      req_src = SRC_RAM;
      if (!aligned)
         req_src = SRC_ZERO;
      else if (led_hit)
         req_src = SRC_LED;
      else if (cyc_hit)
         req_src = SRC_CYC;
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      src_next   = src_reg;
      load_en    = 1'b0;
      load_idx   = idx_reg;
      load_src   = src_reg;
      stall      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rd_req) begin
               stall    = 1'b1;
               cnt_next = CNT_INIT;
               idx_next = req_idx;
               src_next = req_src;
               if (LATENCY == 1) begin
                  load_en    = 1'b1;
                  load_idx   = req_idx;
                  load_src   = req_src;
                  state_next = DONE;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (cnt_reg == 3'd1) begin
               load_en    = 1'b1;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg - 3'd1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      load_data = 32'h0;
      case (load_src)
         SRC_RAM:  load_data = ram[load_idx];
         SRC_LED:  load_data = {24'h0, led_val};
         SRC_CYC:  load_data = cyc_val;
         default:  load_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         src_reg   <= SRC_RAM;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         src_reg   <= src_next;
         if (load_en)
            rdata_reg <= load_data;
      end
   end

   // RAM has no reset so contents survive an aborted access.
   always_ff @(posedge clk) begin
      if (ram_we)
         ram[req_idx] <= i_wdata;
   end

   assign o_rdata = rdata_reg;
   assign o_stall = stall & rst;
   assign o_led   = led_val;

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized self-checking bench for dmem_resp against a word-array memory model.
// Second instance exercises LATENCY=1, DEPTH=16 aliasing.
module tb_dmem_resp;

   localparam int TB_DEPTH = 256;
   localparam int TB_LAT   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_mem_rd = 1'b0, i_mem_wr = 1'b0;
   logic [31:0] i_addr = '0, i_wdata = '0;
   logic [31:0] o_rdata;
   logic        o_stall, o_misaligned, o_err;
   logic [7:0]  o_led;

   logic        b_rd = 1'b0, b_wr = 1'b0;
   logic [31:0] b_addr = '0, b_wdata = '0;
   logic [31:0] b_rdata;
   logic        b_stall, b_mis, b_err;
   logic [7:0]  b_led;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic [31:0] mem_model [TB_DEPTH];
   logic [31:0] last_rdata = '0;
   logic [7:0]  led_model  = '0;

   always #5 clk = ~clk;

   dmem_resp #(.DEPTH(TB_DEPTH), .LATENCY(TB_LAT)) u_dut (
      .clk(clk), .rst(rst), .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
      .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_stall(o_stall),
      .o_misaligned(o_misaligned), .o_err(o_err), .o_led(o_led)
   );

   dmem_resp #(.DEPTH(16), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .i_mem_rd(b_rd), .i_mem_wr(b_wr),
      .i_addr(b_addr), .i_wdata(b_wdata), .o_rdata(b_rdata), .o_stall(b_stall),
      .o_misaligned(b_mis), .o_err(b_err), .o_led(b_led)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      if (a % 4 != 0) return 32'h0;
`ifdef DMEM_MMIO_EN
      if (a == 32'hFFFF_FFF0) return {24'h0, led_model};
`endif
      return mem_model[int'((a / 4) % TB_DEPTH)];
   endfunction

   task automatic do_read(input logic [31:0] a, input logic chk, output logic [31:0] got);
      int stalls;
      logic [31:0] exp;
      exp = exp_read(a);
      @(negedge clk);
      i_mem_rd = 1'b1; i_mem_wr = 1'b0; i_addr = a;
      #1;
      stalls = 0;
      while (o_stall && stalls < 16) begin
         check_val("rd_hold", o_rdata, last_rdata);
         stalls++;
         @(negedge clk); #1;
      end
      check_val("rd_lat", 32'(stalls), 32'(TB_LAT));
      check_val("rd_mis", {31'b0, o_misaligned}, {31'b0, (a % 4 != 0)});
      if (chk) check_val("rd_data", o_rdata, exp);
      got = o_rdata;
      last_rdata = o_rdata;
      $display("rd  addr=%h data=%h stalls=%0d", a, o_rdata, stalls);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic with_rd);
      @(negedge clk);
      i_mem_rd = with_rd; i_mem_wr = 1'b1; i_addr = a; i_wdata = d;
      #1;
      check_val("wr_stall", {31'b0, o_stall}, 32'h0);
      check_val("wr_mis", {31'b0, o_misaligned}, {31'b0, (a % 4 != 0)});
      check_val("wr_err", {31'b0, o_err}, {31'b0, with_rd});
      check_val("wr_rdata", o_rdata, last_rdata);
`ifdef DMEM_MMIO_EN
      if (a == 32'hFFFF_FFF0) led_model = d[7:0];
      else if (a % 4 == 0) mem_model[int'((a / 4) % TB_DEPTH)] = d;
`else
      if (a % 4 == 0) mem_model[int'((a / 4) % TB_DEPTH)] = d;
`endif
      $display("wr  addr=%h data=%h rd=%0b", a, d, with_rd);
   endtask

   task automatic do_idle();
      @(negedge clk);
      i_mem_rd = 1'b0; i_mem_wr = 1'b0;
      #1;
      check_val("idle_stall", {31'b0, o_stall}, 32'h0);
      check_val("idle_rdata", o_rdata, last_rdata);
      $display("idl rdata=%h", o_rdata);
   endtask

   initial begin
      logic [31:0] got, c1, c2, a, d;
      int stalls, op;

      // Reset state with a read already requested.
      i_mem_rd = 1'b1; b_rd = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_val("rst_stall", {31'b0, o_stall}, 32'h0);
      check_val("rst_rdata", o_rdata, 32'h0);
      check_val("rst_led", {24'h0, o_led}, 32'h0);
      check_val("rst_stall_b", {31'b0, b_stall}, 32'h0);
      @(negedge clk);
      i_mem_rd = 1'b0; b_rd = 1'b0; rst = 1'b1;

      for (int i = 0; i < TB_DEPTH; i++) begin
         @(negedge clk);
         i_mem_wr = 1'b1; i_addr = 32'(i * 4); i_wdata = $urandom;
         mem_model[i] = i_wdata;
      end
      do_idle();

      do_write(32'h10, 32'hDEAD_BEEF, 1'b0);
      do_write(32'h14, 32'h1234_5678, 1'b0);
      do_read(32'h10, 1'b1, got);
      do_read(32'h10, 1'b1, got);
      do_read(32'h14, 1'b1, got);
      do_write(32'h11, 32'hFFFF_FFFF, 1'b0);
      do_read(32'h10, 1'b1, got);
      do_read(32'h12, 1'b1, got);
      do_write(32'h20, 32'h0BAD_F00D, 1'b1);
      do_read(32'h20, 1'b1, got);

      // Reset while the read sits in WAIT; request held across release.
      @(negedge clk);
      i_mem_rd = 1'b1; i_mem_wr = 1'b0; i_addr = 32'h10;
      @(negedge clk); #1;
      check_val("pre_rst_stall", {31'b0, o_stall}, 32'h1);
      rst = 1'b0; #1;
      check_val("mid_rst_stall", {31'b0, o_stall}, 32'h0);
      check_val("mid_rst_rdata", o_rdata, 32'h0);
      last_rdata = 32'h0;
      @(negedge clk);
      rst = 1'b1; #1;
      stalls = 0;
      while (o_stall && stalls < 16) begin stalls++; @(negedge clk); #1; end
      check_val("rerd_lat", 32'(stalls), 32'(TB_LAT));
      check_val("rerd_data", o_rdata, 32'hDEAD_BEEF);
      last_rdata = o_rdata;
      $display("rd  addr=00000010 data=%h stalls=%0d after reset", o_rdata, stalls);

      for (int n = 0; n < 250; n++) begin
         op = int'($urandom_range(0, 9));
         a  = $urandom & 32'h0000_FFFC;
         d  = $urandom;
         if (op <= 3)      do_read(a, 1'b1, got);
         else if (op <= 5) do_write(a, d, 1'b0);
         else if (op == 6) do_write(a | 32'($urandom_range(1, 3)), d, 1'b0);
         else if (op == 7) do_write(a, d, 1'b1);
         else if (op == 8) do_idle();
         else              do_read(a | 32'($urandom_range(1, 3)), 1'b1, got);
      end
      do_idle();

`ifdef DMEM_MMIO_EN
      do_write(32'hFFFF_FFF0, 32'h0000_003C, 1'b0);
      do_idle();
      check_val("led", {24'h0, o_led}, 32'h3C);
      do_read(32'hFFFF_FFF0, 1'b1, got);
      do_read(32'hFFFF_FFF4, 1'b0, c1);
      do_read(32'hFFFF_FFF4, 1'b0, c2);
      check_val("cyc_delta", c2 - c1, 32'(TB_LAT + 1));
`else
      do_write(32'hFFFF_FFF0, 32'h0000_003C, 1'b0);
      do_read(32'hFFFF_FFF0, 1'b1, got);
      check_val("led_tied", {24'h0, o_led}, 32'h0);
`endif

      // LATENCY=1, DEPTH=16 instance: aliasing and single-cycle stall.
      @(negedge clk);
      b_wr = 1'b1; b_addr = 32'h0; b_wdata = 32'hA5; #1;
      check_val("b_wr_stall", {31'b0, b_stall}, 32'h0);
      @(negedge clk);
      b_addr = 32'h4; b_wdata = 32'h5A5A; #1;
      @(negedge clk);
      b_wr = 1'b0; b_rd = 1'b1; b_addr = 32'h40; #1;
      check_val("b_rd_stall", {31'b0, b_stall}, 32'h1);
      @(negedge clk); #1;
      check_val("b_done_stall", {31'b0, b_stall}, 32'h0);
      check_val("b_alias", b_rdata, 32'hA5);
      $display("rd1 addr=00000040 data=%h", b_rdata);
      @(negedge clk);
      b_addr = 32'h44; #1;
      check_val("b_rd2_stall", {31'b0, b_stall}, 32'h1);
      check_val("b_rd2_hold", b_rdata, 32'hA5);
      @(negedge clk); #1;
      check_val("b_rd2_data", b_rdata, 32'h5A5A);
      $display("rd1 addr=00000044 data=%h", b_rdata);
      @(negedge clk);
      b_addr = 32'h42; #1;
      check_val("b_mis", {31'b0, b_mis}, 32'h1);
      @(negedge clk); #1;
      check_val("b_mis_data", b_rdata, 32'h0);
      $display("rd1 addr=00000042 data=%h", b_rdata);
      @(negedge clk);
      b_rd = 1'b0; #1;
      check_val("b_idle_hold", b_rdata, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
